// File: rtl/debug_monitor_ctrl_if.sv
// Signal bundle between the DE2 board I/O (master) and debug_monitor_ctrl (slave).
interface debug_monitor_ctrl_if #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 8,
  parameter int NUM_DIGITS = 4,
  parameter int PAGE_W     = 4
);
  logic                         KeyStep_n;
  logic [PAGE_W-1:0]            PageSel;
  logic                         AutoScroll;
  logic                         Freeze;
  logic [DATA_W-1:0]            Bus;
  logic [NUM_REGS*DATA_W-1:0]   RegFlat;
  logic                         StepPulse;
  logic [15:0]                  StepCount;
  logic [PAGE_W-1:0]            Page;
  logic                         PageErr;
  logic [NUM_DIGITS*7-1:0]      HexSeg;
  logic [NUM_DIGITS-1:0]        DigitChg;

  modport master (
    output KeyStep_n, PageSel, AutoScroll, Freeze, Bus, RegFlat,
    input  StepPulse, StepCount, Page, PageErr, HexSeg, DigitChg
  );

  modport slave (
    input  KeyStep_n, PageSel, AutoScroll, Freeze, Bus, RegFlat,
    output StepPulse, StepCount, Page, PageErr, HexSeg, DigitChg
  );
endinterface

// File: rtl/debug_monitor_ctrl.sv
// Debug controller: debounced single-step pulse, page selection/auto-scroll, 7-segment display.
// Optional macro DBG_CHANGE_HILITE_EN adds per-digit change flags after each step.
module debug_monitor_ctrl #(
  parameter int DATA_W       = 16,
  parameter int NUM_REGS     = 8,
  parameter int NUM_DIGITS   = 4,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int SCROLL_CYC   = 25000000,
  parameter int PAGE_W       = 4
) (
  input logic                 Clock,
  input logic                 Reset,
  debug_monitor_ctrl_if.slave dbg
);

  localparam int SNAP_W = 4 * NUM_DIGITS;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYC);
  localparam int SCR_W  = $clog2(SCROLL_CYC);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SCR_W-1:0]  SCR_LAST  = SCR_W'(SCROLL_CYC - 1);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_REGS);

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              deb_q, deb_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              step_pulse_q, step_pulse_d;
  logic [15:0]       step_count_q, step_count_d;
  logic              auto_prev_q, auto_prev_d;
  logic [SCR_W-1:0]  scroll_cnt_q, scroll_cnt_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              page_err_q, page_err_d;
  logic [DATA_W-1:0] src;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [NUM_DIGITS*7-1:0] hex_seg;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  // The counter only runs while the synced level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_comb begin
    sync1_d   = dbg.KeyStep_n;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) deb_d = sync2_q;
      else                       deb_cnt_d = deb_cnt_q + 1'b1;
    end
    step_pulse_d = deb_q & ~deb_d;
    step_count_d = step_count_q + {15'd0, step_pulse_d};
  end

  always_comb begin
    page_d       = page_q;
    page_err_d   = page_err_q;
    scroll_cnt_d = scroll_cnt_q;
    auto_prev_d  = dbg.AutoScroll;
    if (!dbg.AutoScroll) begin
      scroll_cnt_d = '0;
      if (dbg.PageSel <= LAST_PAGE) begin
        page_d     = dbg.PageSel;
        page_err_d = 1'b0;
      end else begin
        page_d     = '0;
        page_err_d = 1'b1;
      end
    end else begin
      page_err_d = 1'b0;
      if (!auto_prev_q) begin
        scroll_cnt_d = '0;
      end else if (scroll_cnt_q == SCR_LAST) begin
        scroll_cnt_d = '0;
        page_d       = (page_q >= LAST_PAGE) ? '0 : page_q + 1'b1;
      end else begin
        scroll_cnt_d = scroll_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    src = dbg.Bus;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (page_q == PAGE_W'(k + 1)) src = dbg.RegFlat[k*DATA_W +: DATA_W];
    end
    snap_d = snap_q;
    if (!dbg.Freeze) begin
      snap_d              = '0;
      snap_d[DATA_W-1:0]  = src;
    end
    hex_seg = '0;
    for (int d = 0; d < NUM_DIGITS; d++) hex_seg[d*7 +: 7] = seg7(snap_q[d*4 +: 4]);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      deb_q        <= 1'b1;
      deb_cnt_q    <= '0;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
      auto_prev_q  <= 1'b0;
      scroll_cnt_q <= '0;
      page_q       <= '0;
      page_err_q   <= 1'b0;
      snap_q       <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
      auto_prev_q  <= auto_prev_d;
      scroll_cnt_q <= scroll_cnt_d;
      page_q       <= page_d;
      page_err_q   <= page_err_d;
      snap_q       <= snap_d;
    end
  end

  assign dbg.StepPulse = step_pulse_q;
  assign dbg.StepCount = step_count_q;
  assign dbg.Page      = page_q;
  assign dbg.PageErr   = page_err_q;
  assign dbg.HexSeg    = hex_seg;

`ifdef DBG_CHANGE_HILITE_EN
  localparam int HL_W = $clog2(2 * DEBOUNCE_CYC);
  localparam logic [HL_W-1:0] HL_LAST = HL_W'(2 * DEBOUNCE_CYC - 1);

  logic [SNAP_W-1:0]     rec_q, rec_d;
  logic [HL_W-1:0]       hl_cnt_q, hl_cnt_d;
  logic                  hl_busy_q, hl_busy_d;
  logic [NUM_DIGITS-1:0] digit_chg_q, digit_chg_d;

  // Snapshot is captured on the step pulse and compared once the delay expires.
  always_comb begin
    rec_d       = rec_q;
    hl_cnt_d    = hl_cnt_q;
    hl_busy_d   = hl_busy_q;
    digit_chg_d = digit_chg_q;
    if (step_pulse_q) begin
      rec_d     = snap_q;
      hl_cnt_d  = '0;
      hl_busy_d = 1'b1;
    end else if (hl_busy_q) begin
      if (hl_cnt_q == HL_LAST) begin
        hl_busy_d = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++)
          digit_chg_d[d] = (snap_q[d*4 +: 4] != rec_q[d*4 +: 4]);
      end else begin
        hl_cnt_d = hl_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rec_q       <= '0;
      hl_cnt_q    <= '0;
      hl_busy_q   <= 1'b0;
      digit_chg_q <= '0;
    end else begin
      rec_q       <= rec_d;
      hl_cnt_q    <= hl_cnt_d;
      hl_busy_q   <= hl_busy_d;
      digit_chg_q <= digit_chg_d;
    end
  end

  assign dbg.DigitChg = digit_chg_q;
`else
  assign dbg.DigitChg = '0;
`endif

endmodule

// File: tb/tb_debug_monitor_ctrl.sv
// Self-checking bench for debug_monitor_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a window-based reference model.
module tb_debug_monitor_ctrl;

  localparam int DEB    = 4;
  localparam int SCROLL = 8;
  localparam int NREGS  = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         keyN;
  logic [3:0]   pageSel;
  logic         autoScroll;
  logic         freeze;
  logic [15:0]  busVal;
  logic [127:0] regFlat;

  int testCount = 0;
  int failCount = 0;
  int obsPulses = 0;

  // Reference model state (values expected right after each clock edge)
  int          rawHist[$];
  bit          mDeb;
  bit          mPulse;
  logic [15:0] mCount;
  int          mPage;
  bit          mErr;
  bit          mPrevAuto;
  int          mScrollN;
  logic [15:0] mSnap;
  logic [15:0] mRec;
  logic [3:0]  mChg;
  int          mHlAge;

  always #5 clock = ~clock;

  debug_monitor_ctrl_if #(.DATA_W(16), .NUM_REGS(NREGS), .NUM_DIGITS(4), .PAGE_W(4)) dbgIf ();

  assign dbgIf.KeyStep_n  = keyN;
  assign dbgIf.PageSel    = pageSel;
  assign dbgIf.AutoScroll = autoScroll;
  assign dbgIf.Freeze     = freeze;
  assign dbgIf.Bus        = busVal;
  assign dbgIf.RegFlat    = regFlat;

  debug_monitor_ctrl #(
    .DATA_W(16), .NUM_REGS(NREGS), .NUM_DIGITS(4),
    .DEBOUNCE_CYC(DEB), .SCROLL_CYC(SCROLL), .PAGE_W(4)
  ) dut (
    .Clock (clock),
    .Reset (reset),
    .dbg   (dbgIf.slave)
  );

  function automatic logic [6:0] segOf(input logic [3:0] n);
    logic [6:0] table16 [16];
    table16 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return table16[n];
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Debounce: accepted level follows the synced level (raw delayed two edges) once the
  // last DEB synced samples all agree on a level different from the accepted one.
  task automatic modelStep();
    bit          oldPulse;
    int          oldPage;
    logic [15:0] oldSnap;
    logic [15:0] srcVal;
    bit          newDeb;
    int          n;
    bit          same;
    oldPulse = mPulse;
    oldPage  = mPage;
    oldSnap  = mSnap;
    if (reset) begin
      rawHist.push_back(1);
      mDeb = 1; mPulse = 0; mCount = 0; mPage = 0; mErr = 0;
      mPrevAuto = 0; mScrollN = 0; mSnap = 0; mRec = 0; mChg = 0; mHlAge = -1;
    end else begin
      rawHist.push_back(int'(keyN));
      n = rawHist.size();
      newDeb = mDeb;
      if (n >= DEB + 2) begin
        same = 1;
        for (int j = 1; j < DEB; j++)
          if (rawHist[n-3-j] != rawHist[n-3]) same = 0;
        if (same && (rawHist[n-3] != int'(mDeb))) newDeb = rawHist[n-3][0];
      end
      mPulse = mDeb && !newDeb;
      mCount = mCount + (mPulse ? 16'd1 : 16'd0);
      mDeb   = newDeb;

      srcVal = (oldPage == 0) ? busVal : regFlat[(oldPage-1)*16 +: 16];
      if (!freeze) mSnap = srcVal;

`ifdef DBG_CHANGE_HILITE_EN
      if (oldPulse) begin
        mRec   = oldSnap;
        mHlAge = 0;
      end else if (mHlAge >= 0) begin
        mHlAge++;
        if (mHlAge == 2 * DEB) begin
          for (int d = 0; d < 4; d++) mChg[d] = (oldSnap[d*4 +: 4] != mRec[d*4 +: 4]);
          mHlAge = -1;
        end
      end
`endif

      if (autoScroll) begin
        mErr = 0;
        if (!mPrevAuto) mScrollN = 0;
        else begin
          mScrollN++;
          if (mScrollN % SCROLL == 0) mPage = (mPage + 1) % (NREGS + 1);
        end
      end else if (int'(pageSel) <= NREGS) begin
        mPage = int'(pageSel);
        mErr  = 0;
      end else begin
        mPage = 0;
        mErr  = 1;
      end
      mPrevAuto = autoScroll;
    end
    if (rawHist.size() > 16) void'(rawHist.pop_front());
  endtask

  task automatic checkOutput();
    logic [27:0] expHex;
    for (int d = 0; d < 4; d++) expHex[d*7 +: 7] = segOf(mSnap[d*4 +: 4]);
    if (dbgIf.StepPulse === 1'b1) obsPulses++;
    checkVal("StepPulse", 32'(dbgIf.StepPulse), 32'(mPulse));
    checkVal("StepCount", 32'(dbgIf.StepCount), 32'(mCount));
    checkVal("Page",      32'(dbgIf.Page),      32'(mPage));
    checkVal("PageErr",   32'(dbgIf.PageErr),   32'(mErr));
    checkVal("HexSeg",    32'(dbgIf.HexSeg),    32'(expHex));
    checkVal("DigitChg",  32'(dbgIf.DigitChg),  32'(mChg));
  endtask

  task automatic applyStimulus(input logic k, input logic [3:0] ps, input logic au,
                               input logic fr, input logic [15:0] b);
    keyN = k; pageSel = ps; autoScroll = au; freeze = fr; busVal = b;
    @(posedge clock);
    #1;
    modelStep();
    checkOutput();
  endtask

  task automatic idle(input int cycles, input logic k, input logic [3:0] ps,
                      input logic au, input logic fr, input logic [15:0] b);
    for (int i = 0; i < cycles; i++) applyStimulus(k, ps, au, fr, b);
  endtask

  initial begin
    int holdLeft;
    logic kR, auR;
    logic [3:0] psR;

    reset = 1'b1; keyN = 1'b1; pageSel = '0; autoScroll = 1'b0; freeze = 1'b0;
    busVal = '0; regFlat = '0;
    mHlAge = -1;

    // Reset values
    idle(3, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000);
    checkVal("rst_count", 32'(dbgIf.StepCount), 32'd0);
    checkVal("rst_page",  32'(dbgIf.Page),      32'd0);
    checkVal("rst_hex",   32'(dbgIf.HexSeg),    32'({4{7'b1000000}}));
    reset = 1'b0;
    idle(1, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000);
    checkVal("rel_hex",   32'(dbgIf.HexSeg),    32'({4{7'b1000000}}));

    // Bouncy press then a long hold: one pulse only
    obsPulses = 0;
    idle(2, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
    idle(2, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000);
    idle(20, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
    idle(12, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000);
    checkVal("press_pulses", 32'(obsPulses), 32'd1);
    checkVal("press_count",  32'(dbgIf.StepCount), 32'd1);
    idle(3, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
    idle(10, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000);
    checkVal("glitch_pulses", 32'(obsPulses), 32'd1);
    checkVal("glitch_count",  32'(dbgIf.StepCount), 32'd1);

    // Register page display
    regFlat[2*16 +: 16] = 16'hBEEF;
    idle(2, 1'b1, 4'd3, 1'b0, 1'b0, 16'h0000);
    checkVal("page3",     32'(dbgIf.Page), 32'd3);
    checkVal("page3_hex", 32'(dbgIf.HexSeg),
             32'({7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}));
    idle(1, 1'b1, 4'd12, 1'b0, 1'b0, 16'h0000);
    checkVal("bad_page", 32'(dbgIf.Page),    32'd0);
    checkVal("bad_err",  32'(dbgIf.PageErr), 32'd1);

    // Auto-scroll from page 7
    idle(1, 1'b1, 4'd7, 1'b0, 1'b0, 16'h0000);
    idle(1, 1'b1, 4'd7, 1'b1, 1'b0, 16'h0000);
    idle(8, 1'b1, 4'd7, 1'b1, 1'b0, 16'h0000);
    checkVal("scroll_8", 32'(dbgIf.Page), 32'd8);
    idle(8, 1'b1, 4'd7, 1'b1, 1'b0, 16'h0000);
    checkVal("scroll_0", 32'(dbgIf.Page), 32'd0);
    idle(8, 1'b1, 4'd7, 1'b1, 1'b0, 16'h0000);
    checkVal("scroll_1", 32'(dbgIf.Page), 32'd1);
    idle(1, 1'b1, 4'd5, 1'b0, 1'b0, 16'h0000);
    checkVal("manual_5", 32'(dbgIf.Page), 32'd5);

    // Freeze holds the bus snapshot
    idle(2, 1'b1, 4'd0, 1'b0, 1'b0, 16'h1234);
    idle(1, 1'b1, 4'd0, 1'b0, 1'b1, 16'h1234);
    idle(3, 1'b1, 4'd0, 1'b0, 1'b1, 16'h5678);
    checkVal("frozen_hex", 32'(dbgIf.HexSeg),
             32'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
    idle(1, 1'b1, 4'd0, 1'b0, 1'b0, 16'h5678);
    checkVal("thawed_hex", 32'(dbgIf.HexSeg),
             32'({7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}));

    // Reset arriving mid-debounce
    reset = 1'b1;
    idle(2, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    obsPulses = 0;
    idle(4, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    idle(2, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    idle(10, 1'b1, 4'd0, 1'b0, 1'b0, 16'h0000);
    checkVal("midreset_count",  32'(dbgIf.StepCount), 32'd0);
    checkVal("midreset_pulses", 32'(obsPulses), 32'd0);

`ifdef DBG_CHANGE_HILITE_EN
    // Bus changes after a step; only digit 0 differs when the compare fires
    idle(3, 1'b1, 4'd0, 1'b0, 1'b0, 16'h00F0);
    idle(8, 1'b0, 4'd0, 1'b0, 1'b0, 16'h00F0);
    idle(20, 1'b0, 4'd0, 1'b0, 1'b0, 16'h00FF);
    checkVal("hilite", 32'(dbgIf.DigitChg), 32'b0001);
    idle(10, 1'b1, 4'd0, 1'b0, 1'b0, 16'h00FF);
`endif

    // Randomized traffic against the model
    holdLeft = 0; kR = 1'b1; psR = 4'd0; auR = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (holdLeft == 0) begin
        kR = ~kR;
        holdLeft = $urandom_range(1, 14);
      end
      holdLeft--;
      if ($urandom_range(0, 7) == 0)  psR = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) auR = ~auR;
      if ($urandom_range(0, 49) == 0) regFlat = {$urandom, $urandom, $urandom, $urandom};
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus(kR, psR, auR, ($urandom_range(0, 9) == 0), 16'($urandom));
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
